poly_sqnorm_bound: RTL and testbench
====================================

# poly_sqnorm_bound

Streaming squared-norm accumulator with norm-bound check for the Falcon signing datapath. Parametrised successor to the single-coefficient small-polynomial sqnorm unit. Adds several lanes per beat, a two-polynomial mode for ||(s1,s2)||², overflow detection and a bound comparison. Sits after the signature decompressor / s1 recomputation and feeds the sign-accept decision.

## Interface
- LOGN, 9: log2 of polynomial degree N; legal range 2..10.
- LANES, 1: coefficients consumed per beat; power of two, 1..8, must be ≤ N.
- COEF_W, 16: signed coefficient width.
- ACC_W, 32: accumulator, bound and running-sum width.
- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ena  in  1  frame enable; low = synchronous abort/clear.
- mode  in  1  0 = one polynomial (N coefs); 1 = pair s1 then s2 (2N coefs).
- bound  in  ACC_W  unsigned acceptance bound.
- f_valid  in  1  beat valid.
- f  in  LANES*COEF_W  signed coefficients; lane k at bits [k*COEF_W +: COEF_W], lane 0 = lowest index.
- s_valid  out  1  running sum valid, one pulse per accepted beat.
- s  out  ACC_W  running squared norm including the current beat.
- done  out  1  pulses together with the s_valid of the frame's last beat.
- accept  out  1  (s ≤ bound) && !ovf; valid only while done=1, otherwise 0.
- ovf  out  1  sticky overflow within the current frame.

## Operation
- Beat = cycle with ena=1 and f_valid=1. f_valid with ena=0 is ignored.
- Beats per frame: B = N/LANES for mode 0, 2N/LANES for mode 1.
- mode and bound are sampled on the first beat of a frame and held internally for the rest of the frame.
- FSM states:
  - IDLE → ACC on the first beat.
  - ACC → FLUSH on beat B.
  - FLUSH lasts 2 cycles while the pipeline drains, then returns to IDLE.
- ena=0 from any state → IDLE next cycle. Pipeline, beat counter, accumulator and ovf are all cleared.
- f_valid may drop between beats (bubbles). The frame continues, with no s_valid for the bubble cycles.
- Stage 1:
  - Each lane is squared into an unsigned 2*COEF_W-1 bit value; (−2^(COEF_W−1))² fits exactly.
  - Lane squares are summed by an adder tree of width 2*COEF_W−1+log2(LANES).
  - The stage is registered.
- Stage 2:
  - acc ← acc + tree_sum, computed in ACC_W+1 bits.
  - A carry out of ACC_W sets ovf. ovf stays set until frame end or abort.
- The accumulator clears automatically after done, so the next frame starts at 0.
- A new frame may begin on the cycle after the last beat. Its stage-1 beat overlaps the FLUSH of the previous frame, and the accumulator clear and first add must not collide.

## Timing
- Reset values: s_valid=0, s=0, done=0, accept=0, ovf=0, FSM=IDLE.
- Latency: a beat accepted at edge t produces s_valid/s at edge t+2.
- Throughput: one beat per cycle, no backpressure.
- s holds its last value between pulses. It returns to 0 one cycle after done or after an abort.
- done, accept and the final s all appear at t_last+2.
- Abort with ena=0 at edge t:
  - No s_valid at t+1 or later for beats in flight.
  - s=0 and ovf=0 at t+1.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronously).
- ena and f_valid rising together at negedge-driven stimulus: the first beat counts.

## Configuration
- SQNORM_SAT_EN defined: on overflow the accumulator clamps to 2^ACC_W−1 and stays there for the rest of the frame. ovf=1, accept=0.
- SQNORM_SAT_EN undefined: the accumulator wraps modulo 2^ACC_W. ovf is still sticky and still forces accept=0.

## Test plan
- Parameters LOGN=2, LANES=1, COEF_W=8, ACC_W=16, mode=0:
  - Stimulus f = 1, −2, 3, −4, bound=30 → s = 1, 5, 14, 30; done with s=30; accept=1.
  - Repeat with bound=29 → accept=0.
- Parameters LANES=2, mode=1: s1 = {1,1,1,1}, s2 = {2,2,2,2}, 4 beats → s = 2, 4, 12, 20; done on the 4th pulse; bound=20 → accept=1.
- Overflow, with f = −128 ×4 (LANES=1, ACC_W=16):
  - Sums run 16384, 32768, 49152, then overflow.
  - SQNORM_SAT_EN defined → final s=65535, ovf=1, accept=0.
  - SQNORM_SAT_EN undefined → final s=0, ovf=1, accept=0.
- Abort and bubbles:
  - Two beats, then ena=0 for 1 cycle → s=0 and no s_valid on the following cycles.
  - The next frame f = 1, 1, 1, 1 with bubbles inserted → s = 1, 2, 3, 4, done asserted.
- Back-to-back frames and reset:
  - Frame 2 starts the cycle after frame 1's last beat → frame 2's sums start from 0.
  - rst_n pulsed mid-frame → all outputs read 0 asynchronously; FSM returns to IDLE.

Source files
------------

// File: rtl/poly_sqnorm_bound.sv
// poly_sqnorm_bound: streaming squared-norm accumulator with norm-bound check.
// LANES signed coefficients per beat are squared and summed (stage 1), then
// added into a running accumulator with carry-out overflow detection (stage 2).
// The result is registered onto s/s_valid two edges after the beat is sampled.
// Build option: define SQNORM_SAT_EN to clamp the accumulator at 2^ACC_W-1 on
// overflow; otherwise it wraps. ovf is sticky per frame and forces accept=0.
//
// state | meaning
// IDLE  | no frame open, waiting for the first beat
// ACC   | frame open, counting beats down to the last one
// FLUSH | last beat taken, pipeline draining (a new frame may start here)
module poly_sqnorm_bound #(
  parameter int LOGN   = 9,
  parameter int LANES  = 1,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ena,
  input  logic                      mode,
  input  logic [ACC_W-1:0]          bound,
  input  logic                      f_valid,
  input  logic [LANES*COEF_W-1:0]   f,
  output logic                      s_valid,
  output logic [ACC_W-1:0]          s,
  output logic                      done,
  output logic                      accept,
  output logic                      ovf
);

  localparam int TW = 2*COEF_W - 1 + $clog2(LANES);
  localparam int CW = LOGN + 2;
  localparam int B0 = (1 << LOGN) / LANES;
  localparam logic [CW-1:0] B0_C = CW'(B0);
  localparam logic [CW-1:0] B1_C = CW'(2*B0);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;

  state_t state, state_nxt;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] b_load;
  logic flush_cnt;
  logic beat, first_beat, last_beat;

  logic signed [COEF_W-1:0]   lane;
  logic signed [2*COEF_W-1:0] prod;
  logic [TW-1:0]              tree_sum;

  logic             s1_valid, s1_first, s1_last;
  logic [TW-1:0]    s1_sq;
  logic [ACC_W-1:0] s1_bound;

  logic             s2_valid, s2_last, acc_ovf;
  logic [ACC_W-1:0] acc, s2_bound;
  logic [ACC_W-1:0] acc_base, acc_nxt;
  logic [ACC_W:0]   sum;
  logic             ovf_base, ovf_new;

  assign beat       = ena & f_valid;
  assign first_beat = beat && (state != ACC);
  assign b_load     = mode ? B1_C : B0_C;
  assign last_beat  = first_beat ? (b_load == CW'(1)) : (beat && beat_cnt == CW'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: a first beat is legal in FLUSH so frames can run back to back
  always_comb begin
    state_nxt = state;
    if (!ena) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (first_beat) state_nxt = last_beat ? FLUSH : ACC;
        ACC:     if (last_beat) state_nxt = FLUSH;
        FLUSH: begin
          if (first_beat)              state_nxt = last_beat ? FLUSH : ACC;
          else if (flush_cnt == 1'b0)  state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Beat down-counter (remaining beats after the current one) and flush timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      flush_cnt <= 1'b0;
    end else if (!ena) begin
      beat_cnt  <= '0;
      flush_cnt <= 1'b0;
    end else begin
      if (beat) beat_cnt <= first_beat ? (b_load - CW'(1)) : (beat_cnt - CW'(1));
      if (last_beat)                          flush_cnt <= 1'b1;
      else if (state == FLUSH && flush_cnt)   flush_cnt <= 1'b0;
    end
  end

  // Lane squares summed; the square of -2^(COEF_W-1) never sets the sign bit
  always_comb begin
    tree_sum = '0;
    lane     = '0;
    prod     = '0;
    for (int k = 0; k < LANES; k++) begin
      lane     = f[k*COEF_W +: COEF_W];
      prod     = lane * lane;
      tree_sum = tree_sum + TW'($unsigned(prod));
    end
  end

  // Stage 1: register squared sum with frame tags; bound is captured on the first beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sq    <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_bound <= '0;
    end else if (!ena) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= beat;
      if (beat) begin
        s1_sq    <= tree_sum;
        s1_first <= first_beat;
        s1_last  <= last_beat;
      end
      if (first_beat) s1_bound <= bound;
    end
  end

  // A first-beat tag restarts from zero, so a new frame never sees the old total
  always_comb begin
    acc_base = s1_first ? '0 : acc;
    ovf_base = s1_first ? 1'b0 : acc_ovf;
    sum      = {1'b0, acc_base} + (ACC_W+1)'(s1_sq);
    ovf_new  = ovf_base | sum[ACC_W];
`ifdef SQNORM_SAT_EN
    acc_nxt  = ovf_new ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_nxt  = sum[ACC_W-1:0];
`endif
  end

  // Stage 2: accumulator and sticky overflow, bound travels with the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_bound <= '0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
    end else if (!ena) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      acc      <= '0;
      acc_ovf  <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        acc      <= acc_nxt;
        acc_ovf  <= ovf_new;
        s2_last  <= s1_last;
        s2_bound <= s1_bound;
      end
    end
  end

  // Output stage: s/ovf hold between pulses and return to zero the cycle after done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid <= 1'b0;
      s       <= '0;
      done    <= 1'b0;
      accept  <= 1'b0;
      ovf     <= 1'b0;
    end else if (!ena) begin
      s_valid <= 1'b0;
      s       <= '0;
      done    <= 1'b0;
      accept  <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      s_valid <= s2_valid;
      done    <= s2_valid && s2_last;
      accept  <= s2_valid && s2_last && !acc_ovf && (acc <= s2_bound);
      if (s2_valid) begin
        s   <= acc;
        ovf <= acc_ovf;
      end else if (done) begin
        s   <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_sqnorm_bound.sv
// Scoreboard bench for poly_sqnorm_bound: two instances (LANES=1 and LANES=2,
// N=4, 8-bit coefficients, 16-bit accumulator) share clock, reset and ena.
module tb_poly_sqnorm_bound;

  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b0;

  logic        mode_a = 1'b0, fv_a = 1'b0;
  logic [15:0] bound_a = '0;
  logic [7:0]  f_a = '0;
  logic        sv_a, done_a, accept_a, ovf_a;
  logic [15:0] s_a;

  logic        mode_b = 1'b0, fv_b = 1'b0;
  logic [15:0] bound_b = '0;
  logic [15:0] f_b = '0;
  logic        sv_b, done_b, accept_b, ovf_b;
  logic [15:0] s_b;

  bit finish_req = 1'b0;
  int tests = 0, fails = 0;

  typedef struct {
    logic [15:0] s;
    logic        done;
    logic        acc;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [15:0] last_s [2];
  logic        last_ovf [2];
  logic        prev_done [2];

  poly_sqnorm_bound #(.LOGN(2), .LANES(1), .COEF_W(8), .ACC_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode_a), .bound(bound_a),
    .f_valid(fv_a), .f(f_a), .s_valid(sv_a), .s(s_a), .done(done_a),
    .accept(accept_a), .ovf(ovf_a));

  poly_sqnorm_bound #(.LOGN(2), .LANES(2), .COEF_W(8), .ACC_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .mode(mode_b), .bound(bound_b),
    .f_valid(fv_b), .f(f_b), .s_valid(sv_b), .s(s_b), .done(done_b),
    .accept(accept_b), .ovf(ovf_b));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check_dut(input int k, input logic clr, input logic sv,
                           input logic [15:0] s, input logic dn,
                           input logic ac, input logic ov);
    exp_t e;
    logic [15:0] es;
    logic eo;
    tests++;
    if (clr) begin
      if (sv !== 1'b0 || s !== 16'd0 || dn !== 1'b0 || ac !== 1'b0 || ov !== 1'b0) begin
        fails++;
        $display("FAIL clear_dut%0d: got sv=%0d s=%0d done=%0d accept=%0d ovf=%0d, want all 0",
                 k, sv, s, dn, ac, ov);
      end
      if (k == 0) q0.delete(); else q1.delete();
      last_s[k] = '0; last_ovf[k] = 1'b0; prev_done[k] = 1'b0;
    end else if (sv === 1'b1) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        fails++;
        $display("FAIL unexpected_valid_dut%0d: got s_valid=1 s=%0d, want no pulse", k, s);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (s !== e.s || dn !== e.done || ac !== e.acc || ov !== e.ovf) begin
          fails++;
          $display("FAIL beat_dut%0d: got s=%0d done=%0d accept=%0d ovf=%0d, want s=%0d done=%0d accept=%0d ovf=%0d",
                   k, s, dn, ac, ov, e.s, e.done, e.acc, e.ovf);
        end
        last_s[k] = e.s; last_ovf[k] = e.ovf; prev_done[k] = e.done;
      end
    end else begin
      es = prev_done[k] ? 16'd0 : last_s[k];
      eo = prev_done[k] ? 1'b0 : last_ovf[k];
      if (s !== es || ov !== eo || dn !== 1'b0 || ac !== 1'b0) begin
        fails++;
        $display("FAIL hold_dut%0d: got s=%0d ovf=%0d done=%0d accept=%0d, want s=%0d ovf=%0d done=0 accept=0",
                 k, s, ov, dn, ac, es, eo);
      end
      last_s[k] = es; last_ovf[k] = eo; prev_done[k] = 1'b0;
    end
  endtask

  // Monitor: samples 1 time unit after every rising clock and every reset assertion
  initial begin
    logic clr;
    for (int i = 0; i < 2; i++) begin
      last_s[i] = '0; last_ovf[i] = 1'b0; prev_done[i] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (finish_req) begin
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
          fails++;
          $display("FAIL drain: got %0d/%0d expected results never produced, want 0/0",
                   q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
      clr = !rst_n || !ena;
      check_dut(0, clr, sv_a, s_a, done_a, accept_a, ovf_a);
      check_dut(1, clr, sv_b, s_b, done_b, accept_b, ovf_b);
    end
  end

  task automatic idle_cycle();
    @(negedge clk);
    ena  = 1'b1;
    fv_a = 1'b0;
    fv_b = 1'b0;
    f_a  = 8'($urandom);
    f_b  = 16'($urandom);
  endtask

  // ena low for one cycle with f_valid high on both: beats must be ignored
  task automatic abort_cycle();
    @(negedge clk);
    ena  = 1'b0;
    fv_a = 1'b1;
    fv_b = 1'b1;
    f_a  = 8'($urandom);
    f_b  = 16'($urandom);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    fv_a = 1'b0;
    fv_b = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int rnd_coef();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 255)) - 128;
    return int'($urandom_range(0, 40)) - 20;
  endfunction

  // Drive up to nbeats beats of a frame to instance k and predict every pulse.
  // The model is the plain running sum of squares of all coefficients so far.
  task automatic send(input int k, input int m, input int bnd, input int c[8],
                      input int nbeats, input int maxbub);
    int lanes, nb, bub, idx;
    longint sum;
    exp_t e;
    lanes = (k == 0) ? 1 : 2;
    nb    = ((m != 0) ? 8 : 4) / lanes;
    sum   = 0;
    for (int j = 0; j < nbeats && j < nb; j++) begin
      bub = (maxbub > 0) ? int'($urandom_range(0, maxbub)) : 0;
      repeat (bub) idle_cycle();
      @(negedge clk);
      ena = 1'b1;
      if (k == 0) begin
        fv_b    = 1'b0;
        fv_a    = 1'b1;
        f_a     = 8'(c[j]);
        mode_a  = (j == 0) ? 1'(m) : 1'($urandom_range(0, 1));
        bound_a = (j == 0) ? 16'(bnd) : 16'($urandom);
      end else begin
        fv_a    = 1'b0;
        fv_b    = 1'b1;
        f_b     = {8'(c[2*j+1]), 8'(c[2*j])};
        mode_b  = (j == 0) ? 1'(m) : 1'($urandom_range(0, 1));
        bound_b = (j == 0) ? 16'(bnd) : 16'($urandom);
      end
      for (int l = 0; l < lanes; l++) begin
        idx = j*lanes + l;
        sum = sum + longint'(c[idx]) * longint'(c[idx]);
      end
      e.ovf = (sum > 65535);
`ifdef SQNORM_SAT_EN
      e.s = e.ovf ? 16'hFFFF : 16'(sum);
`else
      e.s = 16'(sum);
`endif
      e.done = (j == nb - 1);
      e.acc  = e.done && !e.ovf && (int'(e.s) <= bnd);
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  // Stimulus
  initial begin
    int c[8];
    int k, m, bnd, nbt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) idle_cycle();

    // 1, -2, 3, -4: sums 1, 5, 14, 30
    send(0, 0, 30, '{1, -2, 3, -4, 0, 0, 0, 0}, 4, 0);
    repeat (3) idle_cycle();
    send(0, 0, 29, '{1, -2, 3, -4, 0, 0, 0, 0}, 4, 0);
    repeat (3) idle_cycle();

    // Pair mode, two lanes: sums 2, 4, 12, 20
    send(1, 1, 20, '{1, 1, 1, 1, 2, 2, 2, 2}, 4, 0);
    repeat (3) idle_cycle();

    // Overflow: 16384, 32768, 49152, then past 2^16-1
    send(0, 0, 65535, '{-128, -128, -128, -128, 0, 0, 0, 0}, 4, 0);
    repeat (3) idle_cycle();

    // Abort after two beats, then a bubbled frame
    send(0, 0, 100, '{5, 6, 7, 8, 0, 0, 0, 0}, 2, 0);
    abort_cycle();
    send(0, 0, 10, '{1, 1, 1, 1, 0, 0, 0, 0}, 4, 2);
    repeat (3) idle_cycle();

    // Back-to-back frames on the same instance
    send(0, 1, 40000, '{100, -100, 50, 3, 7, -9, 11, 2}, 8, 0);
    send(0, 0, 5, '{1, 1, 1, 1, 0, 0, 0, 0}, 4, 0);
    send(1, 0, 9, '{2, 1, -2, 0, 0, 0, 0, 0}, 2, 0);
    send(1, 1, 500, '{3, 4, 5, 6, 7, 8, 9, 10}, 4, 0);
    repeat (3) idle_cycle();

    // Reset asserted mid-frame, then a fresh frame from IDLE
    send(0, 1, 1000, '{9, 9, 9, 9, 9, 9, 9, 9}, 3, 0);
    reset_pulse();
    send(0, 0, 20, '{2, 2, 2, 2, 0, 0, 0, 0}, 4, 0);
    repeat (3) idle_cycle();

    // Randomized frames: mixed modes, bubbles, back-to-back, partial frames with abort
    for (int r = 0; r < 60; r++) begin
      k = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) c[i] = rnd_coef();
      bnd = int'($urandom_range(0, 6000));
      if ($urandom_range(0, 5) == 0) begin
        nbt = int'($urandom_range(1, 3));
        send(k, m, bnd, c, nbt, 1);
        abort_cycle();
      end else begin
        send(k, m, bnd, c, 8, 2);
        if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) idle_cycle();
      end
    end

    for (int i = 0; i < 30; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      idle_cycle();
    end
    finish_req = 1'b1;
  end

endmodule
